// File: rtl/ic_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ic_fill_ctrl
// Description : Instruction-cache miss responder. Captures a miss line
//               address, issues one burst read to memory, assembles the
//               returned beats into a full line and hands it back to the
//               i_cache with a single-cycle ic_miss_ack.
// Revision    : 1.0 - initial release
// ============================================================================
module ic_fill_ctrl #(
    parameter int ADDR_W = 15,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [LINE_W-1:0] ic_fill_data,
    output logic              ic_miss_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic              busy
);

    // Line geometry
    localparam int c_nbeats = LINE_W / BEAT_W;
    localparam int c_cnt_w  = (c_nbeats > 1) ? $clog2(c_nbeats) : 1;
    localparam int c_off_w  = $clog2(LINE_W / 8);

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_nbeats - 1);

    // FSM state encoding
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_req   = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_ack   = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_beat_cnt;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_ack;
    logic               r_busy;

    logic               w_beat_we;
    logic [ADDR_W-1:0]  w_line_addr;

    // The byte offset within the line is irrelevant to a line fill; folding
    // it into an otherwise unused net documents that it is deliberately dropped.
    logic               w_offset_unused;
    assign w_offset_unused = ^ic_addr[c_off_w-1:0];

    // A beat is only accepted while collecting; rvalid elsewhere is stray.
    assign w_beat_we   = (r_state == c_st_data) && mem_rvalid;
    assign w_line_addr = {ic_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};

    // Fill sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_beat_cnt <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (ic_miss) begin
                        r_mem_addr <= w_line_addr;
                        r_beat_cnt <= '0;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (mem_rvalid) begin
                        r_beat_cnt <= r_beat_cnt + c_cnt_one;
                        if (r_beat_cnt == c_cnt_last) begin
                            r_ack   <= 1'b1;
                            r_state <= c_st_ack;
                        end
                    end
                end
                c_st_ack: begin
                    r_state <= c_st_drain;
                end
                c_st_drain: begin
                    // i_cache drops the serviced miss during this cycle.
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    // One register per beat slot; each slot keeps the previous line until
    // its own beat of the next fill arrives.
    generate
        for (genvar gi = 0; gi < c_nbeats; gi++) begin : g_slot
            logic [BEAT_W-1:0] r_beat;

            // Capture this slot's beat when the counter points at it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_beat <= '0;
                end else if (w_beat_we && (r_beat_cnt == c_cnt_w'(gi))) begin
                    r_beat <= mem_rdata;
                end
            end

            assign ic_fill_data[gi*BEAT_W +: BEAT_W] = r_beat;
        end
    endgenerate

    assign ic_miss_ack = r_ack;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ic_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ic_fill_ctrl
// Description : Self-checking bench for ic_fill_ctrl. The bench plays the
//               memory side and checks the line against a beat-slot model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ic_fill_ctrl;

    localparam int ADDR_W = 15;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ic_miss = 1'b0;
    logic [ADDR_W-1:0] ic_addr = '0;
    logic [LINE_W-1:0] ic_fill_data;
    logic              ic_miss_ack;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [BEAT_W-1:0] mem_rdata = '0;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the line the i_cache should currently see.
    logic [LINE_W-1:0] exp_line = '0;
    logic [BEAT_W-1:0] beat_v [4];
    int                bub_v  [4];

    ic_fill_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_miss      (ic_miss),
        .ic_addr      (ic_addr),
        .ic_fill_data (ic_fill_data),
        .ic_miss_ack  (ic_miss_ack),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BEAT_W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fill transaction seen from the memory side. Starts and ends in an
    // IDLE cycle, 1 time unit after a rising edge.
    task automatic run_fill(input logic [ADDR_W-1:0] addr, input int gnt_dly,
                            input bit stray, input bit hold_miss, input string tag);
        logic [ADDR_W-1:0] exp_addr;
        exp_addr   = addr & ~ADDR_W'(31);
        ic_miss    = 1'b1;
        ic_addr    = addr;
        mem_gnt    = 1'b0;
        mem_rvalid = stray;
        mem_rdata  = rand64();
        tick();
        // first REQ cycle
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s req_start: req=%b addr=%h busy=%b, want req=1 addr=%h busy=1",
                     tag, mem_req, mem_addr, busy, exp_addr);
        end
        ic_addr = ADDR_W'($urandom());
        if (!hold_miss) ic_miss = 1'b0;
        for (int k = 0; k < gnt_dly; k++) begin
            mem_rvalid = stray & $urandom_range(0, 1);
            mem_rdata  = rand64();
            tick();
            n_vec++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
                n_err++;
                $display("FAIL %s req_hold: req=%b addr=%h, want req=1 addr=%h",
                         tag, mem_req, mem_addr, exp_addr);
            end
        end
        mem_gnt    = 1'b1;
        mem_rvalid = stray;
        mem_rdata  = rand64();
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        n_vec++;
        if (mem_req !== 1'b0 || ic_fill_data !== exp_line) begin
            n_err++;
            $display("FAIL %s req_drop: req=%b line=%h, want req=0 line=%h",
                     tag, mem_req, ic_fill_data, exp_line);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < bub_v[i]; j++) begin
                mem_rvalid = 1'b0;
                mem_rdata  = rand64();
                tick();
                n_vec++;
                if (ic_miss_ack !== 1'b0 || ic_fill_data !== exp_line) begin
                    n_err++;
                    $display("FAIL %s bubble: ack=%b line=%h, want ack=0 line=%h",
                             tag, ic_miss_ack, ic_fill_data, exp_line);
                end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat_v[i];
            tick();
            mem_rvalid = 1'b0;
            exp_line[i*BEAT_W +: BEAT_W] = beat_v[i];
            n_vec++;
            if (ic_miss_ack !== (i == 3) || ic_fill_data !== exp_line) begin
                n_err++;
                $display("FAIL %s beat%0d: ack=%b line=%h, want ack=%0d line=%h",
                         tag, i, ic_miss_ack, ic_fill_data, (i == 3), exp_line);
            end
        end
        // ACK cycle: stray rvalid must be ignored from here on
        if (!hold_miss) ic_miss = 1'b0;
        mem_rvalid = stray;
        mem_rdata  = rand64();
        tick();
        n_vec++;
        if (ic_miss_ack !== 1'b0 || busy !== 1'b1 || mem_req !== 1'b0 || ic_fill_data !== exp_line) begin
            n_err++;
            $display("FAIL %s drain: ack=%b busy=%b req=%b line=%h, want 0/1/0 line=%h",
                     tag, ic_miss_ack, busy, mem_req, ic_fill_data, exp_line);
        end
        mem_rvalid = stray;
        mem_rdata  = rand64();
        tick();
        mem_rvalid = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || ic_miss_ack !== 1'b0 || ic_fill_data !== exp_line) begin
            n_err++;
            $display("FAIL %s idle: busy=%b req=%b ack=%b line=%h, want 0/0/0 line=%h",
                     tag, busy, mem_req, ic_miss_ack, ic_fill_data, exp_line);
        end
    endtask

    task automatic set_beats_rand(input int max_bub);
        for (int i = 0; i < 4; i++) begin
            beat_v[i] = rand64();
            bub_v[i]  = $urandom_range(0, max_bub);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || ic_miss_ack !== 1'b0 ||
            mem_addr !== '0 || ic_fill_data !== '0) begin
            n_err++;
            $display("FAIL %s: busy=%b req=%b ack=%b addr=%h line=%h, want all 0",
                     tag, busy, mem_req, ic_miss_ack, mem_addr, ic_fill_data);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        check_all_zero("reset_initial");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("reset_release");
        // random traffic, then asynchronous reset between edges
        ic_miss = 1'b1;
        ic_addr = ADDR_W'($urandom());
        for (int k = 0; k < 6; k++) begin
            mem_gnt    = $urandom_range(0, 1);
            mem_rvalid = $urandom_range(0, 1);
            mem_rdata  = rand64();
            tick();
        end
        #3 rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        ic_miss = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        exp_line = '0;
        tick();
    endtask

    task automatic test_basic_fill();
        beat_v[0] = {16{4'h1}}; beat_v[1] = {16{4'h2}};
        beat_v[2] = {16{4'h3}}; beat_v[3] = {16{4'h4}};
        for (int i = 0; i < 4; i++) bub_v[i] = 0;
        run_fill(15'h1A37, 2, 1'b0, 1'b0, "basic");
        n_vec++;
        if (mem_addr !== 15'h1A20 ||
            ic_fill_data !== {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}) begin
            n_err++;
            $display("FAIL basic_line: addr=%h line=%h", mem_addr, ic_fill_data);
        end
    endtask

    task automatic test_bubble();
        bub_v[2] = 3;
        run_fill(15'h1A37, 2, 1'b0, 1'b0, "bubble");
    endtask

    task automatic test_back_to_back();
        set_beats_rand(0);
        run_fill(ADDR_W'($urandom()), 1, 1'b0, 1'b1, "held_miss");
        set_beats_rand(1);
        run_fill(15'h0040, 1, 1'b0, 1'b0, "new_miss");
    endtask

    task automatic test_reset_mid_fill();
        ic_miss = 1'b1;
        ic_addr = ADDR_W'($urandom());
        tick();
        ic_miss = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rand64();
            tick();
        end
        mem_rvalid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_all_zero("reset_mid_fill");
        tick();
        rst = 1'b0;
        exp_line = '0;
        tick();
        set_beats_rand(1);
        run_fill(ADDR_W'($urandom()), 1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_early_gnt();
        set_beats_rand(1);
        run_fill(ADDR_W'($urandom()), 0, 1'b1, 1'b0, "early_gnt");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            set_beats_rand(2);
            run_fill(ADDR_W'($urandom()), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_bubble();
        test_back_to_back();
        test_reset_mid_fill();
        test_early_gnt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
